// File: rtl/tap_serializer.sv
// Framed serial transmitter: captures N_TAPS parallel taps on an accepted load and
// shifts them out LSB-first as start bit, data, even parity, stop bit.
module tap_serializer #(
  parameter int unsigned N_TAPS     = 4,
  parameter int unsigned CNT_W      = 5,
  parameter bit          IDLE_LEVEL = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_TAPS-1:0] taps,
  input  logic              load,
  output logic              ready,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              done
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] LastBit = CNT_W'(N_TAPS - 1);

  state_e            state_q, state_d;
  logic [N_TAPS-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              parity_q, parity_d;
  logic              ser_out_q, ser_out_d;
  logic              ser_valid_q, ser_valid_d;
  logic              done_q, done_d;

  assign ready     = (state_q == StIdle);
  assign ser_out   = ser_out_q;
  assign ser_valid = ser_valid_q;
  assign done      = done_q;

  // Output registers are loaded with the values belonging to state_d, so every
  // pin is a flop output and the start bit appears one cycle after the load edge.
  // The shifter advances on the edge that presents a data bit, so shreg_q[0] is
  // always the next bit to send and parity_q already covers every bit sent.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    parity_d    = parity_q;
    ser_out_d   = IDLE_LEVEL;
    ser_valid_d = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      StIdle: begin
        if (load) begin
          state_d     = StStart;
          shreg_d     = taps;
          cnt_d       = '0;
          parity_d    = 1'b0;
          ser_out_d   = ~IDLE_LEVEL;
          ser_valid_d = 1'b1;
        end
      end
      StStart: begin
        state_d     = StData;
        ser_out_d   = shreg_q[0];
        ser_valid_d = 1'b1;
        shreg_d     = shreg_q >> 1;
        parity_d    = parity_q ^ shreg_q[0];
      end
      StData: begin
        ser_valid_d = 1'b1;
        if (cnt_q == LastBit) begin
          state_d   = StParity;
          ser_out_d = parity_q;
        end else begin
          ser_out_d = shreg_q[0];
          shreg_d   = shreg_q >> 1;
          parity_d  = parity_q ^ shreg_q[0];
          cnt_d     = cnt_q + CNT_W'(1);
        end
      end
      StParity: begin
        state_d = StStop;
        done_d  = 1'b1;
      end
      StStop: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      shreg_q     <= '0;
      cnt_q       <= '0;
      parity_q    <= 1'b0;
      ser_out_q   <= IDLE_LEVEL;
      ser_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      parity_q    <= parity_d;
      ser_out_q   <= ser_out_d;
      ser_valid_q <= ser_valid_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_tap_serializer.sv
// Scoreboard bench for tap_serializer: three instances (N_TAPS = 4, 2, 32); stimulus
// queues expected serial cycles, a negedge monitor pops and compares them.
module tb_tap_serializer;

  typedef struct {
    int   dut;
    int   test;
    logic out;
    logic valid;
    logic done;
    int   gap;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  reset  = 3'b111;
  logic [2:0]  load   = 3'b000;
  logic [3:0]  taps4  = '0;
  logic [1:0]  taps2  = '0;
  logic [31:0] taps32 = '0;
  logic [2:0]  ready, ser_out, ser_valid, done;

  tap_serializer #(.N_TAPS(4), .CNT_W(5), .IDLE_LEVEL(1'b1)) u_dut4 (
    .clk(clk), .reset(reset[0]), .taps(taps4), .load(load[0]),
    .ready(ready[0]), .ser_out(ser_out[0]), .ser_valid(ser_valid[0]), .done(done[0])
  );

  tap_serializer #(.N_TAPS(2), .CNT_W(2), .IDLE_LEVEL(1'b1)) u_dut2 (
    .clk(clk), .reset(reset[1]), .taps(taps2), .load(load[1]),
    .ready(ready[1]), .ser_out(ser_out[1]), .ser_valid(ser_valid[1]), .done(done[1])
  );

  tap_serializer #(.N_TAPS(32), .CNT_W(6), .IDLE_LEVEL(1'b1)) u_dut32 (
    .clk(clk), .reset(reset[2]), .taps(taps32), .load(load[2]),
    .ready(ready[2]), .ser_out(ser_out[2]), .ser_valid(ser_valid[2]), .done(done[2])
  );

  exp_t expq[$];
  int   n_tests  = 0;
  int   n_fail   = 0;
  int   cur_test = 0;
  int   idle_cnt [3] = '{0, 0, 0};
  logic end_req  = 1'b0;
  logic end_ack  = 1'b0;

  task automatic check(input string name, input int test, input int g,
                       input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s (test %0d, dut%0d) at %0t: got %0h, expected %0h",
               name, test, g, $time, act, expv);
    end
  endtask

  // Monitor: every cycle checks the ready/idle invariants; every start, data,
  // parity or stop cycle consumes one scoreboard entry.
  always @(negedge clk) begin
    exp_t e;
    for (int g = 0; g < 3; g++) begin
      check("ready", cur_test, g, 32'(ready[g]), 32'(!(ser_valid[g] || done[g])));
      if (ser_valid[g] === 1'b1 || done[g] === 1'b1) begin
        if (expq.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_output (test %0d, dut%0d) at %0t: got ser_out=%b done=%b, expected no frame",
                   cur_test, g, $time, ser_out[g], done[g]);
        end else begin
          e = expq.pop_front();
          check("dut_select", e.test, g, 32'(g), 32'(e.dut));
          check("ser_out", e.test, g, 32'(ser_out[g]), 32'(e.out));
          check("ser_valid", e.test, g, 32'(ser_valid[g]), 32'(e.valid));
          check("done", e.test, g, 32'(done[g]), 32'(e.done));
          if (e.gap >= 0) check("idle_gap", e.test, g, 32'(idle_cnt[g]), 32'(e.gap));
        end
        idle_cnt[g] = 0;
      end else begin
        check("idle_level", cur_test, g, 32'(ser_out[g]), 32'(1));
        idle_cnt[g]++;
      end
    end
    if (end_req && !end_ack) begin
      check("queue_drained", cur_test, 0, 32'(expq.size()), 32'(0));
      end_ack = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hand-computed 7-cycle frame for the N_TAPS=4 instance, first bit at seq[0].
  task automatic push4(input int test, input logic [0:6] seq, input int gap);
    exp_t e;
    for (int i = 0; i < 7; i++) begin
      e.dut   = 0;
      e.test  = test;
      e.out   = seq[i];
      e.valid = (i < 6);
      e.done  = (i == 6);
      e.gap   = (i == 0) ? gap : -1;
      expq.push_back(e);
    end
  endtask

  // Reference frame: start 0, data LSB-first, even parity, stop 1.
  task automatic push_model(input int g, input int test, input int n,
                            input logic [31:0] t, input int gap);
    exp_t e;
    logic p;
    p       = 1'b0;
    e.dut   = g;
    e.test  = test;
    e.out   = 1'b0;
    e.valid = 1'b1;
    e.done  = 1'b0;
    e.gap   = gap;
    expq.push_back(e);
    e.gap = -1;
    for (int i = 0; i < n; i++) begin
      e.out = t[i];
      p     = p ^ t[i];
      expq.push_back(e);
    end
    e.out = p;
    expq.push_back(e);
    e.out   = 1'b1;
    e.valid = 1'b0;
    e.done  = 1'b1;
    expq.push_back(e);
  endtask

  task automatic send(input int g, input logic [31:0] t);
    case (g)
      0:       taps4 = t[3:0];
      1:       taps2 = t[1:0];
      default: taps32 = t;
    endcase
    load[g] = 1'b1;
    tick();
    load[g] = 1'b0;
  endtask

  // Loads spaced exactly N+4 cycles apart, so every frame after the first
  // must follow a single idle cycle.
  task automatic sweep_frame(input int g, input int n, input logic [31:0] t, input int gap);
    push_model(g, 6, n, t, gap);
    send(g, t);
    repeat (n + 3) tick();
  endtask

  initial begin
    // 1: reset held with load high
    cur_test = 1;
    reset = 3'b111;
    load  = 3'b111;
    repeat (3) tick();
    reset = 3'b000;
    load  = 3'b000;
    repeat (2) tick();

    // 2: single frame, taps 1011 -> 0,1,1,0,1,1,1
    cur_test = 2;
    push4(2, 7'b0110111, -1);
    send(0, 32'hB);
    repeat (10) tick();

    // 3: load with taps 0000 during the frame is ignored
    cur_test = 3;
    push4(3, 7'b0110111, -1);
    send(0, 32'hB);
    repeat (2) tick();
    taps4   = 4'b0000;
    load[0] = 1'b1;
    tick();
    load[0] = 1'b0;
    repeat (12) tick();

    // 4: continuous load, taps 1111 -> two frames one idle cycle apart
    cur_test = 4;
    push4(4, 7'b0111101, -1);
    push4(4, 7'b0111101, 1);
    taps4   = 4'hF;
    load[0] = 1'b1;
    repeat (9) tick();
    load[0] = 1'b0;
    repeat (12) tick();

    // 5: reset during the second data bit aborts, then a fresh frame (taps 0110)
    cur_test = 5;
    push4(5, 7'b0110111, -1);
    send(0, 32'hB);
    repeat (2) tick();
    reset[0] = 1'b1;
    tick();
    reset[0] = 1'b0;
    expq.delete();
    repeat (3) tick();
    push4(5, 7'b0011001, -1);
    send(0, 32'h6);
    repeat (10) tick();

    // 6: N_TAPS=2 and 32 sweeps against the reference frame model
    cur_test = 6;
    sweep_frame(1, 2, 32'h1, -1);
    sweep_frame(1, 2, 32'h2, 1);
    sweep_frame(1, 2, 32'h3, 1);
    sweep_frame(1, 2, 32'h0, 1);
    repeat (5) tick();
    for (int i = 0; i < 32; i++) sweep_frame(2, 32, 32'h1 << i, (i == 0) ? -1 : 1);
    sweep_frame(2, 32, 32'hA5A5_0F0F, 1);
    sweep_frame(2, 32, 32'h8000_0003, 1);
    repeat (10) tick();

    end_req = 1'b1;
    repeat (5) if (!end_ack) tick();
    if (!end_ack) begin
      $display("FAIL end_handshake: monitor did not respond, expected ack");
      $fatal(1, "monitor stalled");
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
